// File: rtl/pipeline_pkg.sv
// Shared types for the EX-stage forwarding control: mux select encoding
// and the per-stage destination-register record.
package pipeline_pkg;

  localparam int unsigned RA_W = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic            reg_write;
    logic            mem_read;
  } stage_info_t;

  localparam logic [RA_W-1:0] REG_ZERO     = '0;
  localparam stage_info_t     STAGE_BUBBLE = '0;

endpackage

// File: rtl/fwd_compare.sv
// Per-operand forwarding priority comparator: the MEM result beats the WB
// result, and register zero is never forwarded.
module fwd_compare
  import pipeline_pkg::*;
(
  input  logic            en,
  input  logic [RA_W-1:0] rs,
  input  logic            mem_en,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            wb_en,
  input  logic [RA_W-1:0] wb_rd,
  output fwd_sel_t        sel
);

  always_comb begin
    sel = FWD_RF;
    if (en) begin
      if (mem_en && (mem_rd != REG_ZERO) && (mem_rd == rs)) begin
        sel = FWD_MEM;
      end else if (wb_en && (wb_rd != REG_ZERO) && (wb_rd == rs)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/forward_select_ctrl.sv
// EX-stage operand forwarding selects and load-use stall generation.
// Define FORWARD_SELECT_WB_FWD_EN to enable forwarding from the WB stage.
module forward_select_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_count
);

  stage_info_t     ex_q, mem_q, wb_q;
  logic [RA_W-1:0] ex_rs1_q, ex_rs2_q;
  logic [RA_W-1:0] rs1, rs2;
  logic            mem_en, wb_en;
  fwd_sel_t        sel_a, sel_b;
  logic            unused_bits;

  assign rs1 = RA_W'(id_rs1);
  assign rs2 = RA_W'(id_rs2);

  // A load sitting in EX cannot supply its data to the instruction in ID yet.
  assign stall = id_valid && !flush && ex_q.valid && ex_q.mem_read &&
                 (ex_q.rd != REG_ZERO) && ((ex_q.rd == rs1) || (ex_q.rd == rs2));

  assign mem_en = mem_q.valid && mem_q.reg_write;
`ifdef FORWARD_SELECT_WB_FWD_EN
  assign wb_en  = wb_q.valid && wb_q.reg_write;
`else
  assign wb_en  = 1'b0;
`endif

  // Fields kept for pipeline tracking but not consumed by any decision.
  assign unused_bits = ^{ex_q.reg_write, mem_q.mem_read, wb_q};

  // Pipeline advance: flush and stall both inject a bubble into EX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q        <= STAGE_BUBBLE;
      mem_q       <= STAGE_BUBBLE;
      wb_q        <= STAGE_BUBBLE;
      ex_rs1_q    <= REG_ZERO;
      ex_rs2_q    <= REG_ZERO;
      stall_count <= '0;
    end else begin
      mem_q <= ex_q;
      wb_q  <= mem_q;
      if (flush || stall) begin
        ex_q     <= STAGE_BUBBLE;
        ex_rs1_q <= REG_ZERO;
        ex_rs2_q <= REG_ZERO;
      end else begin
        ex_q.valid     <= id_valid;
        ex_q.rd        <= RA_W'(id_rd);
        ex_q.reg_write <= id_reg_write;
        ex_q.mem_read  <= id_mem_read;
        ex_rs1_q       <= rs1;
        ex_rs2_q       <= rs2;
      end
      if (!flush && stall && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

  fwd_compare u_cmp_a (
    .en     (ex_q.valid),
    .rs     (ex_rs1_q),
    .mem_en (mem_en),
    .mem_rd (mem_q.rd),
    .wb_en  (wb_en),
    .wb_rd  (wb_q.rd),
    .sel    (sel_a)
  );

  fwd_compare u_cmp_b (
    .en     (ex_q.valid),
    .rs     (ex_rs2_q),
    .mem_en (mem_en),
    .mem_rd (mem_q.rd),
    .wb_en  (wb_en),
    .wb_rd  (wb_q.rd),
    .sel    (sel_b)
  );

  assign fwd_a_sel = sel_a;
  assign fwd_b_sel = sel_b;

endmodule

// File: tb/tb_forward_select_ctrl.sv
// Directed vector bench for forward_select_ctrl, built with a 4-bit stall
// counter so saturation is reachable.
module tb_forward_select_ctrl;

`ifdef FORWARD_SELECT_WB_FWD_EN
  localparam logic [1:0] WB_SEL = 2'b01;
`else
  localparam logic [1:0] WB_SEL = 2'b00;
`endif
  localparam int unsigned CW = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_reg_write, id_mem_read, flush;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall;
  logic [CW-1:0] stall_count;

  int n_vec = 0;
  int n_bad = 0;

  forward_select_ctrl #(.REG_ADDR_W(5), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .stall        (stall),
    .stall_count  (stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2, rd;
    logic       rw, mr, fl;
    logic [1:0] ea, eb;
    logic       es;
    logic [3:0] ec;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(int v, int rs1, int rs2, int rd, int rw, int mr,
                              int fl, logic [1:0] ea, logic [1:0] eb, int es, int ec);
    vec_t t;
    t.v = 1'(v);   t.rs1 = 5'(rs1); t.rs2 = 5'(rs2); t.rd = 5'(rd);
    t.rw = 1'(rw); t.mr = 1'(mr);   t.fl = 1'(fl);
    t.ea = ea;     t.eb = eb;       t.es = 1'(es);   t.ec = 4'(ec);
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int v, input int rs1, input int rs2, input int rd,
                       input int rw, input int mr, input int fl);
    id_valid = 1'(v); id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rd = 5'(rd);
    id_reg_write = 1'(rw); id_mem_read = 1'(mr); flush = 1'(fl);
  endtask

  task automatic check_all(input string tag, input logic [1:0] ea, input logic [1:0] eb,
                           input logic es, input logic [3:0] ec);
    chk({tag, "_a"}, 32'(fwd_a_sel), 32'(ea));
    chk({tag, "_b"}, 32'(fwd_b_sel), 32'(eb));
    chk({tag, "_stall"}, 32'(stall), 32'(es));
    chk({tag, "_cnt"}, 32'(stall_count), 32'(ec));
  endtask

  initial begin
    logic [3:0] exp_cnt;

    // Pipeline trace: EX-EX forward, WB forward, load-use, x0, priority, flush, id_valid=0.
    tbl[0]  = mk(1, 1, 2, 5, 1, 0, 0, 2'b00, 2'b00, 0, 0);   // add x5
    tbl[1]  = mk(1, 5, 6, 8, 1, 0, 0, 2'b00, 2'b00, 0, 0);   // sub rs1=x5
    tbl[2]  = mk(1,10,11,12, 1, 0, 0, 2'b10, 2'b00, 0, 0);   // sub in EX: MEM fwd
    tbl[3]  = mk(1, 1, 1, 7, 1, 0, 0, 2'b00, 2'b00, 0, 0);   // producer x7
    tbl[4]  = mk(1, 2, 3,13, 1, 0, 0, 2'b00, 2'b00, 0, 0);
    tbl[5]  = mk(1, 4, 7,14, 1, 0, 0, 2'b00, 2'b00, 0, 0);   // consumer rs2=x7
    tbl[6]  = mk(1, 0, 0, 3, 1, 1, 0, 2'b00, WB_SEL, 0, 0);  // ld x3; consumer sees WB
    tbl[7]  = mk(1, 3, 4,15, 1, 0, 0, 2'b00, 2'b00, 1, 0);   // load-use stall
    tbl[8]  = mk(1, 3, 4,15, 1, 0, 0, 2'b00, 2'b00, 0, 1);   // held, bubble in EX
    tbl[9]  = mk(1, 1, 2, 0, 1, 0, 0, WB_SEL, 2'b00, 0, 1);  // producer x0
    tbl[10] = mk(1, 0, 0,16, 1, 0, 0, 2'b00, 2'b00, 0, 1);   // consumer rs1=x0
    tbl[11] = mk(1, 1, 1, 9, 1, 0, 0, 2'b00, 2'b00, 0, 1);   // writer x9 #1
    tbl[12] = mk(1, 2, 2, 9, 1, 0, 0, 2'b00, 2'b00, 0, 1);   // writer x9 #2
    tbl[13] = mk(1, 9, 5,17, 1, 0, 0, 2'b00, 2'b00, 0, 1);   // consumer rs1=x9
    tbl[14] = mk(1, 1, 1,18, 1, 0, 0, 2'b10, 2'b00, 0, 1);   // MEM wins over WB
    tbl[15] = mk(1, 0, 0, 3, 1, 1, 0, 2'b00, 2'b00, 0, 1);   // ld x3
    tbl[16] = mk(1, 3, 0,19, 1, 0, 1, 2'b00, 2'b00, 0, 1);   // flush beats stall
    tbl[17] = mk(1, 3, 0,20, 1, 0, 0, 2'b00, 2'b00, 0, 1);   // EX is bubble
    tbl[18] = mk(0, 1, 1, 1, 1, 1, 0, WB_SEL, 2'b00, 0, 1);  // id_valid=0
    tbl[19] = mk(1, 5, 5,21, 1, 0, 0, 2'b00, 2'b00, 0, 1);
    tbl[20] = mk(1, 0, 0, 4, 1, 1, 0, 2'b00, 2'b00, 0, 1);   // ld x4
    tbl[21] = mk(0, 4, 4,22, 1, 0, 0, 2'b00, 2'b00, 0, 1);   // invalid ID never stalls
    tbl[22] = mk(1, 4, 0,23, 1, 0, 0, 2'b00, 2'b00, 0, 1);

    // Reset with garbage on the ID inputs.
    reset = 1'b1;
    drive(1, 3, 3, 3, 1, 1, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset", 2'b00, 2'b00, 1'b0, 4'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 23; i++) begin
      drive(int'(tbl[i].v), int'(tbl[i].rs1), int'(tbl[i].rs2), int'(tbl[i].rd),
            int'(tbl[i].rw), int'(tbl[i].mr), int'(tbl[i].fl));
      @(negedge clk);
      check_all($sformatf("v%0d", i), tbl[i].ea, tbl[i].eb, tbl[i].es, tbl[i].ec);
      @(posedge clk); #1;
    end

    // Repeated load-use stalls drive the 4-bit counter into saturation.
    exp_cnt = 4'd1;
    for (int k = 0; k < 15; k++) begin
      drive(1, 0, 0, 3, 1, 1, 0);
      @(posedge clk); #1;
      drive(1, 3, 0, 24, 1, 0, 0);
      @(negedge clk);
      chk($sformatf("sat%0d_stall", k), 32'(stall), 32'd1);
      @(posedge clk); #1;
      exp_cnt = (exp_cnt == 4'hF) ? 4'hF : exp_cnt + 4'd1;
      @(negedge clk);
      chk($sformatf("sat%0d_nostall", k), 32'(stall), 32'd0);
      chk($sformatf("sat%0d_cnt", k), 32'(stall_count), 32'(exp_cnt));
      @(posedge clk); #1;
    end

    // Asynchronous reset while a MEM forward is active.
    drive(1, 1, 2, 5, 1, 0, 0);
    @(posedge clk); #1;
    drive(1, 5, 6, 8, 1, 0, 0);
    @(posedge clk); #1;
    drive(1, 0, 0, 5, 1, 1, 0);
    @(negedge clk);
    chk("prereset_a", 32'(fwd_a_sel), 32'd2);
    #1 reset = 1'b1;
    #1;
    check_all("midreset", 2'b00, 2'b00, 1'b0, 4'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(1, 5, 5, 10, 1, 0, 0);
    @(negedge clk);
    check_all("postreset", 2'b00, 2'b00, 1'b0, 4'd0);
    @(posedge clk); #1;
    drive(1, 1, 1, 11, 1, 0, 0);
    @(negedge clk);
    check_all("postreset2", 2'b00, 2'b00, 1'b0, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/forward_select_ctrl.md
Name: forward_select_ctrl

Overview:
- Drives the `select` inputs of the operand multiplexors in the EX stage of the 64-bit pipeline. It is the control end of the mux select interface.
- Internally tracks destination-register metadata for the EX, MEM and WB stages. From that state it produces 2-bit forwarding selects per ALU operand and a one-cycle load-use stall.
- Sits between the ID/EX pipeline register and the EX-stage operand muxes. Consumes decoded register fields from ID plus a flush request from branch resolution.

Parameters:
- REG_ADDR_W, 5, width of a register index. Register 0 is hard-wired zero and never forwarded.
- CNT_W, 32, width of the stall event counter.

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-high reset
- id_valid  input  1  ID holds a real instruction
- id_rs1  input  REG_ADDR_W  ID source register 1
- id_rs2  input  REG_ADDR_W  ID source register 2
- id_rd  input  REG_ADDR_W  ID destination register
- id_reg_write  input  1  ID instruction writes rd
- id_mem_read  input  1  ID instruction is a load
- flush  input  1  squash instruction in ID (taken branch)
- fwd_a_sel  output  2  operand A mux select
- fwd_b_sel  output  2  operand B mux select
- stall  output  1  hold PC and IF/ID; insert bubble into EX
- stall_count  output  CNT_W  number of stall cycles since reset

Behaviour:
- Internal state: three stage records EX, MEM and WB.
  - Each record holds {valid, rd, reg_write, mem_read}.
  - EX additionally holds rs1 and rs2.
- Reset (async, active-high): all valid=0, all fields 0, stall_count=0. Consequently fwd_a_sel=00, fwd_b_sel=00, stall=0 during and after reset.
- Select encoding: 00 = register file value, 01 = WB result, 10 = MEM-stage ALU result. 11 is never driven.
- fwd_a_sel is combinational from registered state:
  - 10 if MEM.valid && MEM.reg_write && MEM.rd!=0 && MEM.rd==EX.rs1
  - else 01 if WB.valid && WB.reg_write && WB.rd!=0 && WB.rd==EX.rs1
  - else 00
  - MEM has priority over WB (newest value wins). fwd_b_sel is identical using EX.rs2.
  - Selects are forced 00 when EX.valid=0.
- stall is combinational:
  - Asserted when id_valid && !flush && EX.valid && EX.mem_read && EX.rd!=0 && (EX.rd==id_rs1 || EX.rd==id_rs2).
- Each rising clk edge, in priority order:
  - flush=1: EX <= bubble (valid=0). MEM <= EX, WB <= MEM. stall_count unchanged.
  - stall=1: EX <= bubble. MEM <= EX, WB <= MEM. stall_count += 1, saturating at all-ones (no wrap).
  - Otherwise: EX <= {id_valid, id_*}. MEM <= EX, WB <= MEM.
- Load-use stall lasts exactly one cycle. Next cycle the load is in MEM with mem_read, so it no longer triggers stall; the consumer then gets 01 from WB one cycle later.
- Simultaneous flush and stall condition: flush wins, stall output 0.
- id_valid=0 never stalls and loads a bubble into EX.
- reset asserted mid-operation: all in-flight records are discarded immediately (asynchronous), with no partial forwarding.

Optional Feature:
- Macro: FORWARD_SELECT_WB_FWD_EN.
- Defined: WB-stage forwarding (select 01) is enabled as above.
- Undefined: the WB term is removed, so selects are only 10 or 00. The register file must then be write-before-read. The WB record is still tracked so latency is unchanged.

Decomposition:
- Shared package pipeline_pkg:
  - typedef fwd_sel_t (2-bit enum FWD_RF=00, FWD_WB=01, FWD_MEM=10)
  - typedef stage_info_t (packed struct valid/rd/reg_write/mem_read)
  - constant REG_ZERO
- One sub-module, fwd_compare, is natural: the per-operand priority comparator, instantiated twice (A and B).

Test Plan:
- Reset: assert reset with garbage on id_* -> fwd_a_sel=00, fwd_b_sel=00, stall=0, stall_count=0.
- EX-EX forward: issue add x5 (rd=5, reg_write=1), then sub with rs1=5 -> next cycle, with sub in EX, fwd_a_sel=10, fwd_b_sel=00.
- WB forward: rd=7 producer, one independent instruction, then consumer with rs2=7 -> fwd_b_sel=01. With macro undefined -> 00.
- Load-use: ld x3, then consumer with rs1=3 -> stall=1 for exactly one cycle, stall_count 0->1. Consumer then sees fwd_a_sel=01.
- x0 and priority:
  - Producer rd=0 followed by consumer rs1=0 -> selects 00, no stall.
  - Two back-to-back writers of x9, then consumer rs1=9 -> fwd_a_sel=10 (MEM wins).
- Flush: load x3 in EX, flush=1 with id_rs1=3 -> stall=0, EX becomes bubble, stall_count unchanged. Saturation: preload the count to all-ones via forced stalls (CNT_W=4 build) -> holds at 4'hF.
